// File: rtl/rgb_frame_gen.sv
// rtl/rgb_frame_gen.sv - Test-pattern RGB frame generator with programmable blanking
//
// Produces complete frames of a selectable test pattern on the master side of
// the RGB pixel interface. Each output pixel carries registered RGB data, the
// line-active qualifier, a pixel strobe, an end-of-frame strobe and its X/Y
// coordinate. Horizontal and vertical blanking lengths are parameters.
//
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   enable       run request, sampled in IDLE and at the end of VBLANK
//   hold         stall; freezes all counters and timers while high
//   pattern_sel  0 colour bars, 1 horizontal ramp, 2 vertical ramp, 3 solid
//   solid_color  {R,G,B} used by the solid pattern
//   oRed/oGreen/oBlue  pixel colour, zero whenever oValid is low
//   oValid       line-active qualifier
//   oPixelEn     one strobe per transferred pixel
//   oEof         end-of-frame strobe, coincident with the last pixel
//   oX/oY        coordinate of the current pixel, zero-extended
//   busy         high whenever the generator is not idle
//   frame_cnt    completed-frame counter, wraps naturally
module rgb_frame_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int H_BLANK    = 160,
    parameter int V_BLANK    = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        hold,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_color,
    output logic [7:0]  oRed,
    output logic [7:0]  oGreen,
    output logic [7:0]  oBlue,
    output logic        oValid,
    output logic        oPixelEn,
    output logic        oEof,
    output logic [31:0] oX,
    output logic [31:0] oY,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int BAR_W     = IMG_WIDTH / 8;
    localparam int XW        = $clog2(IMG_WIDTH);
    localparam int YW        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW        = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;
    localparam int PW        = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_HEIGHT - 1);
    localparam logic [BW-1:0] H_LAST   = BW'(H_BLANK - 1);
    localparam logic [BW-1:0] V_LAST   = BW'(V_BLANK - 1);
    localparam logic [PW-1:0] BAR_LAST = PW'(BAR_W - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t        state;
    logic [XW-1:0] xCnt;
    logic [YW-1:0] yCnt;
    logic [BW-1:0] blankCnt;
    logic [PW-1:0] barPos;
    logic [2:0]    barIdx;
    logic [1:0]    selLatch;
    logic [23:0]   colorLatch;

    logic          startFrame;
    logic          lineStart;
    logic          advance;
    logic          emit;
    logic [XW-1:0] emitX;
    logic [YW-1:0] emitY;
    logic [PW-1:0] emitBarPos;
    logic [2:0]    emitBarIdx;
    logic [1:0]    emitSel;
    logic [23:0]   emitColor;
    logic [7:0]    rampX;
    logic [7:0]    rampY;
    logic [23:0]   emitRgb;
    logic          emitEof;

    function automatic logic [23:0] barColor(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // The registers always describe the pixel currently on the outputs, so
    // this block works out which pixel (if any) gets presented at the next edge.
    always_comb begin
        startFrame = !hold && enable &&
                     ((state == IDLE) || (state == VBLANK && blankCnt == V_LAST));
        lineStart  = startFrame || (!hold && state == HBLANK && blankCnt == H_LAST);
        advance    = !hold && state == ACTIVE && xCnt != X_LAST;
        emit       = lineStart || advance;

        emitX = lineStart ? '0 : xCnt + XW'(1);
        // y was already stepped when the line entered HBLANK
        emitY = startFrame ? '0 : yCnt;

        // Bar index tracked incrementally instead of dividing x by the bar width
        if (lineStart) begin
            emitBarPos = '0;
            emitBarIdx = 3'd0;
        end else if (barPos == BAR_LAST) begin
            emitBarPos = '0;
            emitBarIdx = barIdx + 3'd1;
        end else begin
            emitBarPos = barPos + PW'(1);
            emitBarIdx = barIdx;
        end

        // A new frame uses the live inputs; they are latched on the same edge
        emitSel   = startFrame ? pattern_sel : selLatch;
        emitColor = startFrame ? solid_color : colorLatch;
        rampX     = 8'(emitX);
        rampY     = 8'(emitY);

        case (emitSel)
            2'd0:    emitRgb = barColor(emitBarIdx);
            2'd1:    emitRgb = {3{rampX}};
            2'd2:    emitRgb = {3{rampY}};
            default: emitRgb = emitColor;
        endcase

        emitEof = (emitX == X_LAST) && (emitY == Y_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            xCnt       <= '0;
            yCnt       <= '0;
            blankCnt   <= '0;
            barPos     <= '0;
            barIdx     <= 3'd0;
            selLatch   <= 2'd0;
            colorLatch <= 24'd0;
            oRed       <= 8'd0;
            oGreen     <= 8'd0;
            oBlue      <= 8'd0;
            oValid     <= 1'b0;
            oPixelEn   <= 1'b0;
            oEof       <= 1'b0;
            oX         <= 32'd0;
            oY         <= 32'd0;
            busy       <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            oPixelEn <= 1'b0;
            oEof     <= 1'b0;
            if (emit) begin
                state  <= ACTIVE;
                busy   <= 1'b1;
                xCnt   <= emitX;
                yCnt   <= emitY;
                barPos <= emitBarPos;
                barIdx <= emitBarIdx;
                if (startFrame) begin
                    selLatch   <= pattern_sel;
                    colorLatch <= solid_color;
                end
                {oRed, oGreen, oBlue} <= emitRgb;
                oValid   <= 1'b1;
                oPixelEn <= 1'b1;
                oEof     <= emitEof;
                oX       <= 32'(emitX);
                oY       <= 32'(emitY);
                if (emitEof) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end else if (!hold) begin
                case (state)
                    ACTIVE: begin
                        // Last pixel of the line has been shown; enter blanking
                        {oRed, oGreen, oBlue} <= 24'd0;
                        oValid   <= 1'b0;
                        blankCnt <= '0;
                        xCnt     <= '0;
                        if (yCnt == Y_LAST) begin
                            state <= VBLANK;
                        end else begin
                            state <= HBLANK;
                            yCnt  <= yCnt + YW'(1);
                        end
                    end
                    HBLANK: blankCnt <= blankCnt + BW'(1);
                    VBLANK: begin
                        if (blankCnt == V_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            blankCnt <= blankCnt + BW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb_frame_gen.sv
// tb/tb_rgb_frame_gen.sv - Self-checking bench for rgb_frame_gen
module tb_rgb_frame_gen;

    localparam int W  = 16;
    localparam int H  = 4;
    localparam int HB = 3;
    localparam int VB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc    = 0;
    int nTests = 0;
    int nFail  = 0;
    int seen   = 0;

    // main instance
    logic        rst = 1'b1, en = 1'b0, hold = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [23:0] color = 24'd0;
    logic [7:0]  r, g, b;
    logic        valid, pen, eof, busy;
    logic [31:0] ox, oy;
    logic [15:0] fcnt;

    // wide instance (horizontal ramp wrap) and tall instance (vertical ramp wrap)
    logic        rstW = 1'b1, enW = 1'b0, rstT = 1'b1, enT = 1'b0, noHold = 1'b0;
    logic [1:0]  selW = 2'd1, selT = 2'd2;
    logic [23:0] noColor = 24'd0;
    logic [7:0]  rW, gW, bW, rT, gT, bT;
    logic        validW, penW, eofW, busyW, validT, penT, eofT, busyT;
    logic [31:0] oxW, oyW, oxT, oyT;
    logic [15:0] fcntW, fcntT;

    rgb_frame_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .clk(clk), .reset(rst), .enable(en), .hold(hold), .pattern_sel(sel), .solid_color(color),
        .oRed(r), .oGreen(g), .oBlue(b), .oValid(valid), .oPixelEn(pen), .oEof(eof),
        .oX(ox), .oY(oy), .busy(busy), .frame_cnt(fcnt));

    rgb_frame_gen #(.IMG_WIDTH(512), .IMG_HEIGHT(300), .H_BLANK(HB), .V_BLANK(VB)) dutWide (
        .clk(clk), .reset(rstW), .enable(enW), .hold(noHold), .pattern_sel(selW), .solid_color(noColor),
        .oRed(rW), .oGreen(gW), .oBlue(bW), .oValid(validW), .oPixelEn(penW), .oEof(eofW),
        .oX(oxW), .oY(oyW), .busy(busyW), .frame_cnt(fcntW));

    rgb_frame_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(300), .H_BLANK(1), .V_BLANK(1)) dutTall (
        .clk(clk), .reset(rstT), .enable(enT), .hold(noHold), .pattern_sel(selT), .solid_color(noColor),
        .oRed(rT), .oGreen(gT), .oBlue(bT), .oValid(validT), .oPixelEn(penT), .oEof(eofT),
        .oX(oxT), .oY(oyT), .busy(busyT), .frame_cnt(fcntT));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] refRgb(input logic [1:0] s, input int x, input int y,
                                           input int w, input logic [23:0] c);
        logic [7:0]  xv, yv;
        logic [23:0] res;
        xv = 8'(x % 256);
        yv = 8'(y % 256);
        case (s)
            2'd0: begin
                case (x / (w / 8))
                    0:       res = 24'hFFFFFF;
                    1:       res = 24'hFFFF00;
                    2:       res = 24'h00FFFF;
                    3:       res = 24'h00FF00;
                    4:       res = 24'hFF00FF;
                    5:       res = 24'hFF0000;
                    6:       res = 24'h0000FF;
                    default: res = 24'h000000;
                endcase
            end
            2'd1:    res = {xv, xv, xv};
            2'd2:    res = {yv, yv, yv};
            default: res = c;
        endcase
        return res;
    endfunction

    // inputs as the DUT saw them at the last rising edge
    logic        pReset = 1'b1, pHold = 1'b0;
    logic [1:0]  pSel = 2'd0;
    logic [23:0] pColor = 24'd0;

    initial forever begin
        @(posedge clk);
        cyc++;
        pReset = rst;
        pHold  = hold;
        pSel   = sel;
        pColor = color;
    end

    // Stream model: pixels of a frame arrive in raster order k = y*W + x, the
    // pattern is taken from the inputs at the frame's first pixel, line starts
    // are preceded by HB unheld idle cycles, and held/blank cycles follow the
    // freeze and zero-colour rules.
    initial begin
        int k, gap, fcExp, ex, ey;
        logic [1:0]  fSel;
        logic [23:0] fColor;
        logic [87:0] lastPix;
        k = 0; gap = 0; fcExp = 0; fSel = 2'd0; fColor = 24'd0; lastPix = '0;
        forever begin
            @(negedge clk);
            if (pReset) begin
                k = 0; gap = 0; fcExp = 0;
                check("reset_outputs", {r, g, b, valid, pen, eof, ox, oy, busy, fcnt}, '0);
            end else if (pen) begin
                if (k == 0) begin
                    fSel   = pSel;
                    fColor = pColor;
                end
                ex = k % W;
                ey = k / W;
                if (k != 0) check("line_gap", gap, (ex == 0) ? HB : 0);
                if (k == W * H - 1) fcExp = (fcExp + 1) % 65536;
                check("pixel", {ox, oy, r, g, b, valid, eof, fcnt},
                      {32'(ex), 32'(ey), refRgb(fSel, ex, ey, W, fColor), 1'b1,
                       (k == W * H - 1), 16'(fcExp)});
                lastPix = {r, g, b, ox, oy};
                k = (k + 1) % (W * H);
                gap = 0;
                seen++;
            end else begin
                if (!pHold) gap++;
                if (valid) check("hold_freeze", {r, g, b, ox, oy, eof}, {lastPix, 1'b0});
                else       check("blank_outputs", {r, g, b, eof}, '0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1; en = 1'b0; hold = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic waitPix(input string name, input int x, input int y, input int bound);
        bit found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            step();
            if (pen && ox == x && oy == y) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    // counts strobed pixels (matching colour mask optional) up to and including oEof
    task automatic waitEof(input string name, input int bound, input bit matchOnly,
                           input logic [23:0] want, output int nPix);
        bit found;
        found = 1'b0;
        nPix  = 0;
        for (int i = 0; i < bound && !found; i++) begin
            step();
            if (pen && (!matchOnly || {r, g, b} == want)) nPix++;
            if (eof) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    typedef struct {
        logic [1:0]  s;
        logic [23:0] c;
        int          x;
        int          y;
        logic [23:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[12];
        int   t0, nPix, nEof, consec, seen0;
        bit   prevEof, found;
        int   starts[$];

        vecs[0]  = '{2'd0, 24'd0, 0, 0, 24'hFFFFFF};
        vecs[1]  = '{2'd0, 24'd0, 1, 2, 24'hFFFFFF};
        vecs[2]  = '{2'd0, 24'd0, 2, 0, 24'hFFFF00};
        vecs[3]  = '{2'd0, 24'd0, 5, 1, 24'h00FFFF};
        vecs[4]  = '{2'd0, 24'd0, 7, 3, 24'h00FF00};
        vecs[5]  = '{2'd0, 24'd0, 9, 0, 24'hFF00FF};
        vecs[6]  = '{2'd0, 24'd0, 11, 2, 24'hFF0000};
        vecs[7]  = '{2'd0, 24'd0, 13, 1, 24'h0000FF};
        vecs[8]  = '{2'd0, 24'd0, 15, 3, 24'h000000};
        vecs[9]  = '{2'd1, 24'd0, 7, 2, 24'h070707};
        vecs[10] = '{2'd2, 24'd0, 3, 3, 24'h030303};
        vecs[11] = '{2'd3, 24'hA1B2C3, 9, 1, 24'hA1B2C3};

        // colour bars, first-pixel latency, line count, eof, frame counter
        doReset();
        check("reset_state", {r, g, b, valid, pen, eof, ox, oy, busy, fcnt}, '0);
        sel = 2'd0; en = 1'b1;
        step();
        check("t1_first_pixel", {pen, ox, oy, r, g, b}, {1'b1, 32'd0, 32'd0, 24'hFFFFFF});
        en = 1'b0;
        waitEof("t1_eof_found", 200, 1'b0, 24'd0, nPix);
        check("t1_pixel_count", nPix + 1, 64);
        check("t1_eof_pos", {ox, oy}, {32'd15, 32'd3});
        check("t1_frame_cnt", fcnt, 1);
        step(VB + 2);
        check("t1_idle", {busy, valid}, 2'b00);

        // cadence over three back-to-back frames
        doReset();
        sel = 2'd2; en = 1'b1;
        nEof = 0; consec = 0; prevEof = 1'b0;
        for (int i = 0; i < 400 && nEof < 3; i++) begin
            step();
            if (pen && ox == 0 && oy == 0) starts.push_back(cyc);
            if (eof) begin
                nEof++;
                if (prevEof) consec++;
                check("t2_eof_pos", {pen, ox, oy}, {1'b1, 32'd15, 32'd3});
            end
            prevEof = eof;
        end
        en = 1'b0;
        step();
        if (eof) consec++;
        check("t2_eof_count", nEof, 3);
        check("t2_spacing1", (starts.size() >= 2) ? starts[1] - starts[0] : -1, 78);
        check("t2_spacing2", (starts.size() >= 3) ? starts[2] - starts[1] : -1, 78);
        check("t2_frame_cnt", fcnt, 3);
        check("t2_single_cycle_eof", consec, 0);
        step(VB + 2);

        // hold for four cycles at (5,1) on the horizontal ramp
        doReset();
        sel = 2'd1; en = 1'b1;
        step();
        t0 = cyc;
        waitPix("t3_reach_5_1", 5, 1, 100);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_hold_freeze", {r, g, b, valid, pen, eof, ox, oy},
                  {24'h050505, 1'b1, 1'b0, 1'b0, 32'd5, 32'd1});
        end
        hold = 1'b0;
        step();
        check("t3_after_hold", {pen, ox, oy, r, g, b}, {1'b1, 32'd6, 32'd1, 24'h060606});
        waitPix("t3_next_frame", 0, 0, 200);
        check("t3_frame_len", cyc - t0, 82);
        en = 1'b0;

        // pattern change and enable drop mid-frame
        doReset();
        sel = 2'd1; color = 24'h3C5A96; en = 1'b1;
        step();
        waitPix("t4_reach_8_2", 8, 2, 100);
        sel = 2'd3; en = 1'b0;
        waitEof("t4_eof_found", 100, 1'b0, 24'd0, nPix);
        check("t4_eof_ramp", {r, g, b}, 24'h0F0F0F);
        step(VB + 2);
        check("t4_idle", {busy, valid, pen}, 3'b000);
        en = 1'b1;
        step();
        check("t4_solid_first", {pen, r, g, b}, {1'b1, 24'h3C5A96});
        en = 1'b0;
        waitEof("t4_solid_eof", 200, 1'b1, 24'h3C5A96, nPix);
        check("t4_solid_count", nPix + 1, 64);

        // reset mid-frame at (10,2)
        doReset();
        sel = 2'd0; en = 1'b1;
        step();
        waitPix("t5_reach_10_2", 10, 2, 100);
        rst = 1'b1;
        step();
        check("t5_reset_clears", {r, g, b, valid, pen, eof, ox, oy, busy, fcnt}, '0);
        rst = 1'b0;
        step();
        check("t5_restart", {pen, ox, oy, busy}, {1'b1, 64'd0, 1'b1});
        en = 1'b0;
        waitEof("t5_eof_found", 200, 1'b0, 24'd0, nPix);
        check("t5_frame_cnt", fcnt, 1);
        step(VB + 2);

        // table of pattern probes
        for (int i = 0; i < 12; i++) begin
            doReset();
            sel = vecs[i].s; color = vecs[i].c; en = 1'b1;
            waitPix($sformatf("vec%0d_reach", i), vecs[i].x, vecs[i].y, 120);
            check($sformatf("vec%0d_rgb", i), {r, g, b}, vecs[i].exp);
            en = 1'b0;
        end

        // randomized hold / enable / pattern / occasional reset
        doReset();
        seen0 = seen;
        for (int i = 0; i < 2500; i++) begin
            hold = ($urandom_range(0, 3) == 0);
            en   = ($urandom_range(0, 9) != 0);
            rst  = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) begin
                sel   = 2'($urandom_range(0, 3));
                color = 24'($urandom);
            end
            step();
        end
        rst = 1'b0; hold = 1'b0; en = 1'b0;
        check("rand_pixels_seen", (seen - seen0) > 300, 1);

        // horizontal ramp wrap on a 512-wide frame
        step(2);
        rstW = 1'b0; enW = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (penW && oxW == 255) found = 1'b1;
        end
        check("t6_reach_x255", found, 1);
        check("t6_x255", {rW, gW, bW}, 24'hFFFFFF);
        step();
        check("t6_x256", {penW, oxW, oyW, rW, gW, bW}, {1'b1, 32'd256, 32'd0, 24'h000000});
        enW = 1'b0; rstW = 1'b1;

        // vertical ramp wrap on a 300-line frame
        rstT = 1'b0; enT = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            if (penT && oyT == 255) found = 1'b1;
        end
        check("t6_reach_y255", found, 1);
        check("t6_y255", {rT, gT, bT}, 24'hFFFFFF);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (penT && oyT == 256) found = 1'b1;
        end
        check("t6_reach_y256", found, 1);
        check("t6_y256", {oxT, oyT, rT, gT, bT}, {32'd0, 32'd256, 24'h000000});
        enT = 1'b0; rstT = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
